parking_fee_unit: RTL and testbench
===================================

# parking_fee_unit

Billing stage downstream of the parking occupancy circuit. On each accepted exit event it snapshots the leaving spot's elapsed-time counter and converts cycles to billing units with ceiling division. It then multiplies by a per-unit rate, clamps the result to a maximum fee, and reports the fee with a one-cycle valid strobe. It also keeps a running revenue total and a count of exits dropped while busy.

## Interface
- UNIT_CYCLES, 100: clock cycles per billing unit; must be ≥1 (0 is illegal).
- RATE, 5: fee per billing unit.
- MAX_FEE, 200: fee ceiling; must fit in FEE_W bits.
- FEE_W, 16: fee width.
- REV_W, 32: revenue accumulator width.

- CLK  in  1  system clock; all state changes on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- exit  in  1  exit request. Sampled high on a rising edge; same signal that drives the occupancy circuit.
- switch  in  2  index of the spot that is exiting; valid with exit.
- occupied  in  4  per-spot occupancy flags from the occupancy circuit.
- spot0_time..spot3_time  in  64 each  elapsed cycles per spot from the occupancy circuit.
- busy  out  1  high whenever the FSM is not IDLE.
- fee_valid  out  1  one-cycle strobe; fee and fee_spot are valid while it is high.
- fee  out  FEE_W  last computed fee; holds its value between results.
- fee_spot  out  2  spot index of the last fee.
- revenue  out  REV_W  sum of all fees, wrapping modulo 2^REV_W.
- drop_count  out  8  exits dropped while busy, saturating at 255.

## Operation
- FSM states: IDLE, DIV, MUL, DONE.
- IDLE:
  - exit=1 and occupied[switch]=1 at an edge: latch t = spot<switch>_time and fee_spot = switch, then go to DIV.
  - The time snapshot is the value present in the sampling cycle, i.e. before the occupancy circuit clears it at that same edge.
  - exit=1 with occupied[switch]=0: ignored. No state change and no drop count.
- DIV:
  - 64-iteration restoring division of t by UNIT_CYCLES, one quotient bit per cycle.
  - Produces quotient q and remainder r; units = q + (r≠0).
  - After the 64th iteration, go to MUL.
- MUL:
  - product = units × RATE, computed at full width (64+FEE_W bits).
  - fee = MAX_FEE if product > MAX_FEE, else product.
  - Register fee; set fee_valid=1; revenue += fee. Go to DONE.
- DONE: clear fee_valid and go to IDLE.
- Any exit=1 sampled while state≠IDLE (DIV, MUL or DONE) is dropped. drop_count increments, saturating at 255, regardless of occupied.
- t=0 gives units=0 and fee=0; fee_valid still pulses.
- Revenue wraps silently on overflow.

## Timing
- Reset values: busy=0, fee_valid=0, fee=0, fee_spot=0, revenue=0, drop_count=0, state=IDLE.
- Reset asserted mid-operation aborts the computation. The pending fee is lost and no fee_valid is produced.
- With the exit accepted at edge k:
  - DIV iterations occur at edges k+1..k+64.
  - fee, fee_spot, fee_valid=1 and the revenue update are all registered at edge k+65.
  - fee_valid returns to 0 and state returns to IDLE at edge k+66.
- busy is high from edge k up to edge k+66.
- The next exit can be accepted no earlier than edge k+66 sampling in IDLE, i.e. the first edge after the FSM has registered IDLE (k+67).
- Results are produced one at a time; nothing is queued.

## Test plan
- Spot 1 occupied, spot1_time=250, exit pulse at edge k -> fee_valid high exactly one cycle after edge k+65; fee=15 (3 units), fee_spot=1, revenue=15.
- spot0_time=300 (exact multiple) -> fee=15. Then spot0_time=0 -> fee=0, fee_valid pulses, revenue unchanged.
- spot2_time=1_000_000 -> units=10000; fee clamps to 200; revenue increases by 200.
- exit with switch=3 and occupied[3]=0 -> busy stays 0, no fee_valid, drop_count=0.
- Second exit at edge k+10 during DIV -> drop_count=1 and the first fee is unaffected. An exit at edge k+67 is accepted and busy rises.
- RST low at edge k+30 during DIV -> all outputs 0 immediately. After release, no fee_valid is produced and revenue=0.

Source files
------------

// File: rtl/parking_fee_unit.sv
// Billing stage: on an accepted exit, converts the spot's elapsed cycles to a
// clamped fee via 64-step restoring division and one multiply, and tracks revenue.
module parking_fee_unit #(
  parameter int UNIT_CYCLES = 100,
  parameter int RATE        = 5,
  parameter int MAX_FEE     = 200,
  parameter int FEE_W       = 16,
  parameter int REV_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             exit,
  input  logic [1:0]       switch,
  input  logic [3:0]       occupied,
  input  logic [63:0]      spot0_time,
  input  logic [63:0]      spot1_time,
  input  logic [63:0]      spot2_time,
  input  logic [63:0]      spot3_time,
  output logic             busy,
  output logic             fee_valid,
  output logic [FEE_W-1:0] fee,
  output logic [1:0]       fee_spot,
  output logic [REV_W-1:0] revenue,
  output logic [7:0]       drop_count
);

  localparam int PROD_W = 64 + FEE_W;
  localparam logic [64:0]       DIVISOR   = 65'(UNIT_CYCLES);
  localparam logic [FEE_W-1:0]  RATE_L    = FEE_W'(RATE);
  localparam logic [FEE_W-1:0]  MAX_FEE_L = FEE_W'(MAX_FEE);

  typedef enum logic [1:0] {IDLE, DIV, MUL, DONE} state_t;

  state_t      state;
  logic [63:0] dividend;   // shifts out t, shifts in the quotient
  logic [64:0] rem;
  logic [5:0]  iter;

  logic [63:0]       spot_time [4];
  logic [64:0]       rem_shift;
  logic              rem_ge;
  logic [64:0]       rem_next;
  logic [63:0]       quot_next;
  logic [63:0]       units;
  logic [PROD_W-1:0] product;
  logic [FEE_W-1:0]  fee_next;

  assign spot_time[0] = spot0_time;
  assign spot_time[1] = spot1_time;
  assign spot_time[2] = spot2_time;
  assign spot_time[3] = spot3_time;

  // NOTE: every signal written here gets a value on every path so no latch is inferred.
  always_comb begin
    rem_shift = {rem[63:0], dividend[63]};
    rem_ge    = (rem_shift >= DIVISOR);
    rem_next  = rem_ge ? (rem_shift - DIVISOR) : rem_shift;
    quot_next = {dividend[62:0], rem_ge};
    // After division a nonzero remainder rounds up; q cannot be all-ones then.
    units     = dividend + 64'(rem != 65'd0);
    product   = PROD_W'(units) * PROD_W'(RATE_L);
    fee_next  = (product > PROD_W'(MAX_FEE_L)) ? MAX_FEE_L : product[FEE_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      dividend   <= '0;
      rem        <= '0;
      iter       <= '0;
      busy       <= 1'b0;
      fee_valid  <= 1'b0;
      fee        <= '0;
      fee_spot   <= '0;
      revenue    <= '0;
      drop_count <= '0;
    end else begin
      if (exit && state != IDLE && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;

      case (state)
        IDLE: begin
          if (exit && occupied[switch]) begin
            dividend <= spot_time[switch];
            rem      <= '0;
            iter     <= '0;
            fee_spot <= switch;
            busy     <= 1'b1;
            state    <= DIV;
          end
        end
        DIV: begin
          dividend <= quot_next;
          rem      <= rem_next;
          iter     <= iter + 6'd1;
          if (iter == 6'd63)
            state <= MUL;
        end
        MUL: begin
          fee       <= fee_next;
          fee_valid <= 1'b1;
          revenue   <= revenue + REV_W'(fee_next);
          state     <= DONE;
        end
        DONE: begin
          fee_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_fee_unit.sv
// Scoreboard bench for parking_fee_unit: expected fees are queued at exit time
// and compared (value, spot, latency, revenue) when fee_valid pulses.
module tb_parking_fee_unit;

  localparam int UNIT_CYCLES = 100;
  localparam int RATE        = 5;
  localparam int MAX_FEE     = 200;
  localparam int FEE_W       = 16;
  localparam int REV_W       = 32;

  logic             CLK = 1'b0;
  logic             RST;
  logic             exit;
  logic [1:0]       switch;
  logic [3:0]       occupied;
  logic [63:0]      spot0_time, spot1_time, spot2_time, spot3_time;
  logic             busy, fee_valid;
  logic [FEE_W-1:0] fee;
  logic [1:0]       fee_spot;
  logic [REV_W-1:0] revenue;
  logic [7:0]       drop_count;

  parking_fee_unit #(
    .UNIT_CYCLES(UNIT_CYCLES), .RATE(RATE), .MAX_FEE(MAX_FEE),
    .FEE_W(FEE_W), .REV_W(REV_W)
  ) dut (
    .CLK(CLK), .RST(RST), .exit(exit), .switch(switch), .occupied(occupied),
    .spot0_time(spot0_time), .spot1_time(spot1_time),
    .spot2_time(spot2_time), .spot3_time(spot3_time),
    .busy(busy), .fee_valid(fee_valid), .fee(fee), .fee_spot(fee_spot),
    .revenue(revenue), .drop_count(drop_count)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [FEE_W-1:0] fee;
    logic [1:0]       spot;
    int               cyc;
  } exp_t;

  exp_t             sb[$];
  logic [REV_W-1:0] exp_rev = '0;
  int               n_checks = 0;
  int               n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FEE_W-1:0] model_fee(input logic [63:0] t);
    logic [127:0] u, p;
    u = ({64'd0, t} + 128'(UNIT_CYCLES - 1)) / 128'(UNIT_CYCLES);
    p = u * 128'(RATE);
    return (p > 128'(MAX_FEE)) ? FEE_W'(MAX_FEE) : p[FEE_W-1:0];
  endfunction

  function automatic logic [63:0] time_of(input logic [1:0] s);
    case (s)
      2'd0:    return spot0_time;
      2'd1:    return spot1_time;
      2'd2:    return spot2_time;
      default: return spot3_time;
    endcase
  endfunction

  // Monitor: compare every fee strobe against the head of the scoreboard.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge CLK);
      if (prev_valid && RST) check("valid_one_cycle", fee_valid, 0);
      if (fee_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", fee_valid, 0);
        end else begin
          e = sb.pop_front();
          exp_rev = exp_rev + REV_W'(e.fee);
          check("fee", fee, e.fee);
          check("fee_spot", fee_spot, e.spot);
          check("latency", 64'(cyc), 64'(e.cyc + 65));
          check("revenue", revenue, exp_rev);
        end
      end
      prev_valid = fee_valid;
    end
  end

  // Call at a negedge; the exit is sampled at the next rising edge.
  task automatic pulse_exit(input logic [1:0] s, input bit accept, output int k);
    exp_t e;
    k = cyc + 1;
    if (accept) begin
      e.fee  = model_fee(time_of(s));
      e.spot = s;
      e.cyc  = k;
      sb.push_back(e);
    end
    exit   = 1'b1;
    switch = s;
    @(negedge CLK);
    exit = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (busy) check("idle_timeout", busy, 0);
    repeat (2) @(negedge CLK);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  initial begin
    int k, k2;
    RST = 1'b0; exit = 1'b0; switch = 2'd0; occupied = 4'b0000;
    spot0_time = '0; spot1_time = '0; spot2_time = '0; spot3_time = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy", busy, 0);
    check("rst_fee_valid", fee_valid, 0);
    check("rst_fee", fee, 0);
    check("rst_fee_spot", fee_spot, 0);
    check("rst_revenue", revenue, 0);
    check("rst_drop_count", drop_count, 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Ceiling division, exact multiple, zero time, clamp.
    occupied = 4'b0111;
    spot1_time = 64'd250;
    pulse_exit(2'd1, 1'b1, k);
    check("busy_after_accept", busy, 1);
    wait_idle();
    check("revenue_after_first", revenue, 15);
    spot0_time = 64'd300;
    pulse_exit(2'd0, 1'b1, k);
    wait_idle();
    spot0_time = 64'd0;
    pulse_exit(2'd0, 1'b1, k);
    wait_idle();
    check("revenue_zero_fee", revenue, 30);
    spot2_time = 64'd1_000_000;
    pulse_exit(2'd2, 1'b1, k);
    wait_idle();
    check("revenue_clamped", revenue, 230);

    // Exit on an empty spot is ignored entirely.
    pulse_exit(2'd3, 1'b0, k);
    check("empty_spot_busy", busy, 0);
    repeat (80) @(negedge CLK);
    check("empty_spot_drops", drop_count, 0);

    // Drop during DIV, drop in DONE, accept on the first IDLE edge.
    occupied = 4'b1010;
    spot1_time = 64'd500;
    spot3_time = 64'd777;
    pulse_exit(2'd1, 1'b1, k);
    wait_until(k + 9);
    pulse_exit(2'd1, 1'b0, k2);
    check("drop_in_div", drop_count, 1);
    wait_until(k + 65);
    begin
      exp_t e;
      e.fee = model_fee(spot3_time); e.spot = 2'd3; e.cyc = k + 67;
      sb.push_back(e);
    end
    exit = 1'b1; switch = 2'd3;
    repeat (2) @(negedge CLK);
    exit = 1'b0;
    check("accept_at_k67_busy", busy, 1);
    check("drop_in_done", drop_count, 2);
    wait_idle();
    check("revenue_before_reset", revenue, 295);

    // Reset mid-division aborts the pending fee.
    pulse_exit(2'd1, 1'b0, k);
    wait_until(k + 29);
    RST = 1'b0;
    sb.delete();
    exp_rev = '0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_fee_valid", fee_valid, 0);
    check("abort_fee", fee, 0);
    check("abort_fee_spot", fee_spot, 0);
    check("abort_revenue", revenue, 0);
    check("abort_drop_count", drop_count, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (80) @(negedge CLK);
    check("post_abort_revenue", revenue, 0);
    check("post_abort_busy", busy, 0);
    check("sb_empty", 64'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
